// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: per-channel state encoding.
package pulse_stretch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StHold = ST_HOLD,
      StGap  = ST_GAP
   } state_e;

endpackage

// File: rtl/pulse_stretch_channel.sv
// One stretcher channel: edge detect, IDLE/HOLD/GAP FSM, shared counter and a
// single-deep pending flag. Output "active" is active-high; polarity is applied
// by the parent.
module pulse_stretch_channel
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned ON_TIME     = 50000,
   parameter int unsigned OFF_TIME    = 50000,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse_in,
   output logic active,
   output logic busy
);

   localparam logic [COUNT_WIDTH-1:0] OnLast  = COUNT_WIDTH'(ON_TIME - 1);
   // Only meaningful when OFF_TIME > 0; the GAP state is unreachable otherwise.
   localparam logic [COUNT_WIDTH-1:0] OffLast = COUNT_WIDTH'(OFF_TIME - 1);
   localparam bit                     HasGap  = (OFF_TIME > 0);

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   pending_q, pending_d;
   logic                   pulse_prev_q;
   logic                   trig;
   logic                   active_q, busy_q;

   // Next-state, counter and pending-flag logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      trig      = pulse_in & ~pulse_prev_q;

      unique case (state_q)
         StIdle: begin
            if (trig) begin
               state_d = StHold;
               cnt_d   = '0;
            end
         end
         StHold: begin
            if (trig) pending_d = 1'b1;
            if (cnt_q == OnLast) begin
               // Minimum on-time reached; a still-high input keeps us here.
               if (!pulse_in) begin
                  cnt_d = '0;
                  if (HasGap) begin
                     state_d = StGap;
                  end else if (pending_q) begin
                     state_d   = StHold;
                     pending_d = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == OffLast) begin
               cnt_d = '0;
               if (pending_q) begin
                  // Pending is consumed; a trigger on this same edge re-arms it.
                  state_d   = StHold;
                  pending_d = trig;
               end else if (trig) begin
                  state_d = StHold;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (trig) pending_d = 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            cnt_d     = '0;
            pending_d = 1'b0;
         end
      endcase
   end

   // State, counter, edge register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         pulse_prev_q <= 1'b1;  // input already high at release must not trigger
         active_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         pulse_prev_q <= pulse_in;
         active_q     <= (state_d == StHold);
         busy_q       <= (state_d != StIdle) | pending_d;
      end
   end

   assign active = active_q;
   assign busy   = busy_q;

endmodule

// File: rtl/pulse_stretch.sv
// Multi-channel pulse stretcher: WIDTH independent channels, each guaranteeing a
// minimum active time and a minimum inactive gap on its output drive.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned WIDTH       = 6,
   parameter string       POLARITY    = "LOW",
   parameter int unsigned ON_TIME     = 50000,
   parameter int unsigned OFF_TIME    = 50000,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pulse_in,
   output logic [WIDTH-1:0] drive_out,
   output logic [WIDTH-1:0] busy
);

   localparam bit ActiveLow = (POLARITY == "LOW");

   logic [WIDTH-1:0] active;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      pulse_stretch_channel #(
         .ON_TIME     (ON_TIME),
         .OFF_TIME    (OFF_TIME),
         .COUNT_WIDTH (COUNT_WIDTH)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .pulse_in (pulse_in[i]),
         .active   (active[i]),
         .busy     (busy[i])
      );
   end

   // Inversion of a flop output only, so the pin stays glitch-free and registered.
   assign drive_out = ActiveLow ? ~active : active;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: a timestamp-based reference model pushes
// the expected per-edge outputs, and an independent monitor pops and compares.
module tb_pulse_stretch;

   localparam int ON  = 4;
   localparam int OFF = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] pulse_in = 2'b00;
   logic [1:0] drive_h, busy_h, drive_l, busy_l;

   always #5 clk = ~clk;

   pulse_stretch #(
      .WIDTH(2), .POLARITY("HIGH"), .ON_TIME(ON), .OFF_TIME(OFF), .COUNT_WIDTH(4)
   ) dut_h (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .drive_out(drive_h), .busy(busy_h)
   );

   pulse_stretch #(
      .WIDTH(2), .POLARITY("LOW"), .ON_TIME(ON), .OFF_TIME(OFF), .COUNT_WIDTH(4)
   ) dut_l (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .drive_out(drive_l), .busy(busy_l)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [1:0] drive;
      logic [1:0] busy;
   } exp_t;

   exp_t sb_q[$];

   // Model state: edge counter, last active edge and last gap edge per channel.
   int         t = 0;
   int         act_last[2];
   int         gap_last[2];
   bit         pend[2];
   logic [1:0] prev;
   logic       reset_prev = 1'b1;

   logic [1:0] hist_d[40];
   logic [1:0] hist_b[40];

   function automatic void check(input string name, input logic [7:0] act,
                                 input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         act_last[i] = -100;
         gap_last[i] = -100;
         pend[i]     = 1'b0;
      end
      prev = 2'b11;
   endfunction

   // Events in absolute edge numbers: an event started at edge s is active for
   // s..s+ON-1 and rests for the following OFF edges; a high input at the
   // would-be exit edge extends activity by one edge.
   function automatic void model_edge(input logic [1:0] p);
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         logic trig;
         trig = p[i] & ~prev[i];
         if (t == act_last[i] + 1 && p[i]) begin
            act_last[i] = t;
            gap_last[i] = t + OFF;
            if (trig) pend[i] = 1'b1;
         end else if (t <= gap_last[i]) begin
            if (trig) pend[i] = 1'b1;
         end else if (pend[i] || trig) begin
            pend[i]     = pend[i] ? trig : 1'b0;
            act_last[i] = t + ON - 1;
            gap_last[i] = act_last[i] + OFF;
         end
         e.drive[i] = (t <= act_last[i]);
         e.busy[i]  = (t <= gap_last[i]) || pend[i];
      end
      prev = p;
      sb_q.push_back(e);
   endfunction

   // One clock: drive at the falling edge, model the rising edge, return 1 after it.
   task automatic step(input logic [1:0] p, input logic r);
      exp_t e;
      @(negedge clk);
      pulse_in = p;
      reset    = r;
      if (r) begin
         model_reset();
         if (!reset_prev) begin
            #1;
            check("reset_now_high", {4'b0, drive_h, busy_h}, 8'h00);
            check("reset_now_low", {4'b0, drive_l, busy_l}, {4'b0, 2'b11, 2'b00});
         end
      end
      reset_prev = r;
      @(posedge clk);
      if (r) begin
         e = '0;
         sb_q.push_back(e);
      end else begin
         model_edge(p);
      end
      t++;
      #1;
   endtask

   task automatic run_seq(input logic [39:0] p0, input logic [39:0] rs);
      for (int k = 0; k < 40; k++) begin
         step({1'b0, p0[k]}, rs[k]);
         hist_d[k] = drive_h;
         hist_b[k] = busy_h;
      end
   endtask

   // Monitor: every edge the DUTs present fresh registered outputs.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("sb_high", {4'b0, drive_h, busy_h}, {4'b0, e.drive, e.busy});
         check("sb_low", {4'b0, drive_l, busy_l}, {4'b0, ~e.drive, e.busy});
      end
   end

   initial begin
      logic [39:0] p0;
      logic [39:0] rs;
      logic [1:0]  rp;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_high", {4'b0, drive_h, busy_h}, 8'h00);
      check("reset_low", {4'b0, drive_l, busy_l}, {4'b0, 2'b11, 2'b00});
      repeat (3) step(2'b00, 1'b0);

      // Single one-cycle pulse at edge 10.
      p0 = '0; rs = '0; p0[10] = 1'b1;
      run_seq(p0, rs);
      check("single_d9", {6'b0, hist_d[9]}, 8'h00);
      check("single_d10", {6'b0, hist_d[10]}, 8'h01);
      check("single_d13", {6'b0, hist_d[13]}, 8'h01);
      check("single_d14", {6'b0, hist_d[14]}, 8'h00);
      check("single_b16", {6'b0, hist_b[16]}, 8'h01);
      check("single_b17", {6'b0, hist_b[17]}, 8'h00);

      // Input held high for edges 10..19.
      p0 = '0; rs = '0;
      for (int k = 10; k <= 19; k++) p0[k] = 1'b1;
      run_seq(p0, rs);
      check("held_d19", {6'b0, hist_d[19]}, 8'h01);
      check("held_d20", {6'b0, hist_d[20]}, 8'h00);
      check("held_b22", {6'b0, hist_b[22]}, 8'h01);
      check("held_b23", {6'b0, hist_b[23]}, 8'h00);

      // Pulses at 10 and 12: second event pends through the gap.
      p0 = '0; rs = '0; p0[10] = 1'b1; p0[12] = 1'b1;
      run_seq(p0, rs);
      check("pend_d14", {6'b0, hist_d[14]}, 8'h00);
      check("pend_d17", {6'b0, hist_d[17]}, 8'h01);
      check("pend_d20", {6'b0, hist_d[20]}, 8'h01);
      check("pend_d21", {6'b0, hist_d[21]}, 8'h00);
      check("pend_b23", {6'b0, hist_b[23]}, 8'h01);
      check("pend_b24", {6'b0, hist_b[24]}, 8'h00);

      // Third event while already pending is dropped: still two blinks.
      p0 = '0; rs = '0; p0[10] = 1'b1; p0[12] = 1'b1; p0[15] = 1'b1;
      run_seq(p0, rs);
      check("drop_d17", {6'b0, hist_d[17]}, 8'h01);
      check("drop_d21", {6'b0, hist_d[21]}, 8'h00);
      check("drop_b24", {6'b0, hist_b[24]}, 8'h00);
      check("drop_d26", {6'b0, hist_d[26]}, 8'h00);

      // Pulse on the last gap edge restarts with no idle cycle.
      p0 = '0; rs = '0; p0[10] = 1'b1; p0[16] = 1'b1;
      run_seq(p0, rs);
      check("lastgap_d16", {6'b0, hist_d[16]}, 8'h00);
      check("lastgap_d17", {6'b0, hist_d[17]}, 8'h01);
      check("lastgap_d21", {6'b0, hist_d[21]}, 8'h00);

      // Reset mid-HOLD with input held high across release.
      p0 = '0; rs = '0;
      for (int k = 2; k <= 10; k++) p0[k] = 1'b1;
      p0[13] = 1'b1; rs[4] = 1'b1; rs[5] = 1'b1;
      run_seq(p0, rs);
      check("rst_d3", {6'b0, hist_d[3]}, 8'h01);
      check("rst_d7", {6'b0, hist_d[7]}, 8'h00);
      check("rst_b9", {6'b0, hist_b[9]}, 8'h00);
      check("rst_d13", {6'b0, hist_d[13]}, 8'h01);

      // Randomised traffic on both channels with occasional reset.
      for (int n = 0; n < 3000; n++) begin
         rp[0] = ($urandom_range(0, 3) == 0);
         rp[1] = ($urandom_range(0, 4) == 0);
         step(rp, ($urandom_range(0, 299) == 0));
      end

      repeat (3) step(2'b00, 1'b0);
      @(negedge clk);
      check("sb_drain", 8'(sb_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
